// File: rtl/sram_wrapper.sv
// AXI3-style slave bridging single-outstanding read/write bursts onto a
// synchronous single-port SRAM (one-cycle read latency, active-low byte writes).
module sram_wrapper #(
    parameter int unsigned ID_W   = 8,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned MEM_AW = 14
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [ID_W-1:0]   AWID,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [3:0]        AWLEN,
    input  logic [2:0]        AWSIZE,
    input  logic [1:0]        AWBURST,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [DATA_W-1:0] WDATA,
    input  logic [3:0]        WSTRB,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [ID_W-1:0]   BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    input  logic [ID_W-1:0]   ARID,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [3:0]        ARLEN,
    input  logic [2:0]        ARSIZE,
    input  logic [1:0]        ARBURST,
    input  logic              ARVALID,
    output logic              ARREADY,
    output logic [ID_W-1:0]   RID,
    output logic [DATA_W-1:0] RDATA,
    output logic [1:0]        RRESP,
    output logic              RLAST,
    output logic              RVALID,
    input  logic              RREADY,
    output logic              CS,
    output logic              OE,
    output logic [3:0]        WEB,
    output logic [MEM_AW-1:0] A,
    output logic [DATA_W-1:0] DI,
    input  logic [DATA_W-1:0] DO
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WDATA = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ID_W-1:0]     id_q;
    logic [MEM_AW-1:0]   addr_q;
    logic [MEM_AW-1:0]   addr_nxt;
    logic [3:0]          len_q;
    logic [3:0]          beat_q;
    logic [1:0]          burst_q;
    logic                err_q;
    logic                hold_q;
    logic [DATA_W-1:0]   rdata_q;
    logic                last_beat;
    logic                aw_hs;
    logic                ar_hs;
    logic                w_hs;
    logic                r_hs;
    logic                b_hs;
    logic                unused_ok;

    assign unused_ok = ^{AWSIZE, ARSIZE, AWADDR[ADDR_W-1:MEM_AW+2], AWADDR[1:0],
                         ARADDR[ADDR_W-1:MEM_AW+2], ARADDR[1:0]};

    assign last_beat = (beat_q == len_q);
    assign aw_hs     = (state == S_IDLE) && AWVALID;
    assign ar_hs     = (state == S_IDLE) && ARVALID && !AWVALID;
    assign w_hs      = (state == S_WDATA) && WVALID && !ARESET;
    assign r_hs      = (state == S_RDATA) && RREADY;
    assign b_hs      = (state == S_WRESP) && BREADY;
    // FIXED holds the address; INCR, WRAP and reserved all step by one word
    assign addr_nxt  = (burst_q == 2'b00) ? addr_q : addr_q + MEM_AW'(1);

    always_ff @(posedge ACLK) begin
        if (ARESET) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE: begin
                if (AWVALID)      state_next = S_WDATA;
                else if (ARVALID) state_next = S_RADDR;
            end
            S_RADDR: state_next = S_RDATA;
            S_RDATA: if (r_hs) state_next = last_beat ? S_IDLE : S_RADDR;
            S_WDATA: if (w_hs && last_beat) state_next = S_WRESP;
            S_WRESP: if (BREADY) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        AWREADY = 1'b0;
        ARREADY = 1'b0;
        WREADY  = 1'b0;
        BID     = '0;
        BRESP   = 2'b00;
        BVALID  = 1'b0;
        RID     = '0;
        RDATA   = '0;
        RRESP   = 2'b00;
        RLAST   = 1'b0;
        RVALID  = 1'b0;
        CS      = 1'b0;
        OE      = 1'b0;
        WEB     = 4'hF;
        A       = '0;
        DI      = '0;
        unique case (state)
            S_IDLE: begin
                AWREADY = 1'b1;
                ARREADY = !AWVALID;
            end
            S_RADDR: begin
                CS = 1'b1;
                OE = 1'b1;
                A  = addr_q;
            end
            S_RDATA: begin
                RVALID = 1'b1;
                RID    = id_q;
                RDATA  = hold_q ? rdata_q : DO;
                RLAST  = last_beat;
            end
            S_WDATA: begin
                WREADY = !ARESET;
                if (w_hs) begin
                    CS  = 1'b1;
                    WEB = ~WSTRB;
                    A   = addr_q;
                    DI  = WDATA;
                end
            end
            S_WRESP: begin
                BVALID = 1'b1;
                BID    = id_q;
                BRESP  = err_q ? 2'b10 : 2'b00;
            end
            default: ;
        endcase
    end

    // Burst context, beat counter, WLAST error flag and stalled read data
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            burst_q <= '0;
            beat_q  <= '0;
            err_q   <= 1'b0;
            hold_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (aw_hs) begin
                id_q    <= AWID;
                addr_q  <= AWADDR[MEM_AW+1:2];
                len_q   <= AWLEN;
                burst_q <= AWBURST;
                beat_q  <= '0;
                err_q   <= 1'b0;
            end else if (ar_hs) begin
                id_q    <= ARID;
                addr_q  <= ARADDR[MEM_AW+1:2];
                len_q   <= ARLEN;
                burst_q <= ARBURST;
                beat_q  <= '0;
            end
            if (w_hs) begin
                if (WLAST != last_beat) err_q <= 1'b1;
                if (!last_beat) begin
                    beat_q <= beat_q + 4'd1;
                    addr_q <= addr_nxt;
                end
            end
            if (b_hs) err_q <= 1'b0;
            if (state == S_RDATA) begin
                if (r_hs) begin
                    hold_q <= 1'b0;
                    if (!last_beat) begin
                        beat_q <= beat_q + 4'd1;
                        addr_q <= addr_nxt;
                    end
                end else if (!hold_q) begin
                    hold_q  <= 1'b1;
                    rdata_q <= DO;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_wrapper.sv
// Scoreboard bench for sram_wrapper: directed bursts against a behavioural SRAM,
// expected R/B responses queued at issue time and checked by a monitor.
module tb_sram_wrapper;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [7:0]  id;
    } r_exp_t;

    typedef struct {
        logic [7:0] id;
        logic [1:0] resp;
    } b_exp_t;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [7:0]  AWID;
    logic [31:0] AWADDR;
    logic [3:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [7:0]  ARID;
    logic [31:0] ARADDR;
    logic [3:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [7:0]  RID;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        CS;
    logic        OE;
    logic [3:0]  WEB;
    logic [13:0] A;
    logic [31:0] DI;
    logic [31:0] DO;

    logic [31:0] mem [0:16383];
    logic        pl_en = 1'b0;
    logic [13:0] pl_addr;
    logic [31:0] pl_data;

    r_exp_t exp_r[$];
    b_exp_t exp_b[$];
    int     checks = 0;
    int     passes = 0;
    int     stray  = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        toggle_en  = 1'b0;

    sram_wrapper #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .MEM_AW(14)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
        .CS(CS), .OE(OE), .WEB(WEB), .A(A), .DI(DI), .DO(DO)
    );

    always #5 ACLK = ~ACLK;

    // Behavioural synchronous SRAM with a backdoor preload port
    always @(posedge ACLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (CS && !OE) begin
            for (int b = 0; b < 4; b++)
                if (!WEB[b]) mem[A][8*b +: 8] <= DI[8*b +: 8];
        end
        if (CS && OE) DO <= mem[A];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    // Response monitor / scoreboard
    always @(negedge ACLK) begin
        if (prev_stall && RVALID) chk("r_stable", 64'(RDATA), 64'(prev_data));
        prev_stall = RVALID && !RREADY;
        prev_data  = RDATA;
        if (WEB != 4'hF && !(WVALID && WREADY)) stray++;
        if (WEB != 4'hF && OE) stray++;
        if (RVALID && RREADY) begin
            if (exp_r.size() == 0) begin
                chk("r_unexpected", 64'(exp_r.size()), 64'd1);
            end else begin
                r_exp_t e;
                e = exp_r.pop_front();
                chk("rdata", 64'(RDATA), 64'(e.data));
                chk("rlast", 64'(RLAST), 64'(e.last));
                chk("rid",   64'(RID),   64'(e.id));
                chk("rresp", 64'(RRESP), 64'd0);
            end
        end
        if (BVALID && BREADY) begin
            if (exp_b.size() == 0) begin
                chk("b_unexpected", 64'(exp_b.size()), 64'd1);
            end else begin
                b_exp_t e;
                e = exp_b.pop_front();
                chk("bid",   64'(BID),   64'(e.id));
                chk("bresp", 64'(BRESP), 64'(e.resp));
            end
        end
    end

    task automatic preload(input logic [13:0] addr, input logic [31:0] data);
        pl_addr = addr;
        pl_data = data;
        pl_en   = 1'b1;
        @(posedge ACLK);
        #1 pl_en = 1'b0;
    endtask

    task automatic ar_req(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = 3'd2; ARBURST = burst; ARVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 100);
        chk("ar_accept", 64'(ARREADY), 64'd1);
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
    endtask

    task automatic aw_req(input logic [7:0] id, input logic [31:0] addr,
                          input logic [3:0] len, input logic [1:0] burst);
        int n = 0;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = 3'd2; AWBURST = burst; AWVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!AWREADY && n < 100);
        chk("aw_accept", 64'(AWREADY), 64'd1);
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
        do begin @(negedge ACLK); n++; end while (!WREADY && n < 100);
        chk("w_accept", 64'(WREADY), 64'd1);
        @(posedge ACLK);
        #1 WVALID = 1'b0;
    endtask

    task automatic wait_sb(input string name);
        int n = 0;
        while ((exp_r.size() != 0 || exp_b.size() != 0) && n < 200) begin
            @(negedge ACLK);
            n++;
        end
        chk(name, 64'(n < 200), 64'd1);
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        ARESET = 1'b1;
        AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
        ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
        RREADY = 1'b1;
        @(posedge ACLK);
        #1;
        preload(14'h0010, 32'hDEADBEEF);
        preload(14'h0041, 32'hAAAAAAAA);
        preload(14'h3FFF, 32'hCAFEF00D);
        preload(14'h0000, 32'h0BADC0DE);
        preload(14'h0140, 32'h00000000);
        preload(14'h0141, 32'h00000000);
        @(posedge ACLK);
        #1 ARESET = 1'b0;

        // Reset state
        @(negedge ACLK);
        chk("rst_awready", 64'(AWREADY), 64'd1);
        chk("rst_arready", 64'(ARREADY), 64'd1);
        chk("rst_rvalid",  64'(RVALID),  64'd0);
        chk("rst_bvalid",  64'(BVALID),  64'd0);
        chk("rst_wready",  64'(WREADY),  64'd0);
        chk("rst_cs_oe",   64'({CS, OE}), 64'd0);
        chk("rst_web",     64'(WEB),     64'hF);
        chk("rst_rdata",   64'(RDATA),   64'd0);
        chk("rst_bid",     64'({BID, BRESP}), 64'd0);
        @(posedge ACLK);
        #1;

        // Single read, RVALID two cycles after the AR handshake
        exp_r.push_back('{32'hDEADBEEF, 1'b1, 8'h11});
        ar_req(8'h11, 32'h0000_0040, 4'd0, 2'b01);
        @(negedge ACLK);
        chk("rvalid_lat1", 64'(RVALID), 64'd0);
        @(negedge ACLK);
        chk("rvalid_lat2", 64'(RVALID), 64'd1);
        wait_sb("single_read_done");

        // 4-beat INCR write with a half-word strobe on beat 2
        exp_b.push_back('{8'h5A, 2'b00});
        aw_req(8'h5A, 32'h0000_0100, 4'd3, 2'b01);
        w_beat(32'h11111111, 4'hF, 1'b0);
        w_beat(32'h22222222, 4'h3, 1'b0);
        w_beat(32'h33333333, 4'hF, 1'b0);
        w_beat(32'h44444444, 4'hF, 1'b1);
        wait_sb("incr_write_done");
        chk("mem_40", 64'(mem[14'h040]), 64'h11111111);
        chk("mem_41", 64'(mem[14'h041]), 64'hAAAA2222);
        chk("mem_42", 64'(mem[14'h042]), 64'h33333333);
        chk("mem_43", 64'(mem[14'h043]), 64'h44444444);

        // 4-beat read (WRAP encoding acts as INCR) with RREADY stalls
        exp_r.push_back('{32'h11111111, 1'b0, 8'h77});
        exp_r.push_back('{32'hAAAA2222, 1'b0, 8'h77});
        exp_r.push_back('{32'h33333333, 1'b0, 8'h77});
        exp_r.push_back('{32'h44444444, 1'b1, 8'h77});
        RREADY = 1'b0;
        toggle_en = 1'b1;
        fork
            begin
                while (toggle_en) begin
                    repeat (2) @(posedge ACLK);
                    #1 RREADY = !RREADY;
                end
            end
        join_none
        ar_req(8'h77, 32'h0000_0100, 4'd3, 2'b10);
        wait_sb("stalled_read_done");
        toggle_en = 1'b0;
        repeat (3) @(posedge ACLK);
        #1 RREADY = 1'b1;

        // FIXED read repeats the same word
        exp_r.push_back('{32'hDEADBEEF, 1'b0, 8'h50});
        exp_r.push_back('{32'hDEADBEEF, 1'b1, 8'h50});
        ar_req(8'h50, 32'h0000_0040, 4'd1, 2'b00);
        wait_sb("fixed_read_done");

        // Simultaneous AW and AR: write wins, then the read sees the new data
        exp_b.push_back('{8'h21, 2'b00});
        exp_r.push_back('{32'h12345678, 1'b1, 8'h22});
        AWID = 8'h21; AWADDR = 32'h0000_0200; AWLEN = 4'd0; AWBURST = 2'b01; AWVALID = 1'b1;
        ARID = 8'h22; ARADDR = 32'h0000_0200; ARLEN = 4'd0; ARBURST = 2'b01; ARVALID = 1'b1;
        @(negedge ACLK);
        chk("both_awready", 64'(AWREADY), 64'd1);
        chk("both_arready", 64'(ARREADY), 64'd0);
        @(posedge ACLK);
        #1 AWVALID = 1'b0;
        w_beat(32'h12345678, 4'hF, 1'b1);
        n = 0;
        do begin @(negedge ACLK); n++; end while (!ARREADY && n < 100);
        chk("ar_after_write", 64'(ARREADY), 64'd1);
        chk("write_first", 64'(exp_b.size()), 64'd0);
        @(posedge ACLK);
        #1 ARVALID = 1'b0;
        wait_sb("collision_done");

        // Early WLAST flags SLVERR; following burst is clean (upper addr bits ignored)
        exp_b.push_back('{8'h33, 2'b10});
        aw_req(8'h33, 32'h0000_0300, 4'd1, 2'b01);
        w_beat(32'h55555555, 4'hF, 1'b1);
        w_beat(32'h66666666, 4'hF, 1'b1);
        wait_sb("slverr_done");
        chk("mem_c0", 64'(mem[14'h0C0]), 64'h55555555);
        chk("mem_c1", 64'(mem[14'h0C1]), 64'h66666666);
        exp_b.push_back('{8'h34, 2'b00});
        aw_req(8'h34, 32'hABC0_0400, 4'd0, 2'b01);
        w_beat(32'h99999999, 4'hF, 1'b1);
        wait_sb("clean_after_err_done");
        chk("mem_100", 64'(mem[14'h100]), 64'h99999999);

        // Read wrapping past the top of the SRAM
        exp_r.push_back('{32'hCAFEF00D, 1'b0, 8'h60});
        exp_r.push_back('{32'h0BADC0DE, 1'b1, 8'h60});
        ar_req(8'h60, 32'h0000_FFFC, 4'd1, 2'b01);
        wait_sb("wrap_read_done");

        // Reset during a stalled read burst
        RREADY = 1'b0;
        ar_req(8'h44, 32'h0000_0100, 4'd3, 2'b01);
        n = 0;
        do begin @(negedge ACLK); n++; end while (!RVALID && n < 100);
        chk("rd_before_rst", 64'(RVALID), 64'd1);
        @(posedge ACLK);
        #1 ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        @(negedge ACLK);
        chk("rst_mid_rvalid",  64'(RVALID),  64'd0);
        chk("rst_mid_arready", 64'(ARREADY), 64'd1);
        chk("rst_mid_rid",     64'({RID, RDATA}), 64'd0);
        @(posedge ACLK);
        #1 RREADY = 1'b1;

        // Reset during a write burst: no further write, no response
        aw_req(8'h70, 32'h0000_0500, 4'd3, 2'b01);
        w_beat(32'h77770000, 4'hF, 1'b0);
        WDATA = 32'h88888888; WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1; ARESET = 1'b1;
        @(posedge ACLK);
        #1 ARESET = 1'b0;
        WVALID = 1'b0;
        repeat (3) @(negedge ACLK);
        chk("rst_wr_bvalid", 64'(BVALID), 64'd0);
        chk("rst_wr_idle",   64'(AWREADY), 64'd1);
        chk("mem_140", 64'(mem[14'h140]), 64'h77770000);
        chk("mem_141", 64'(mem[14'h141]), 64'h00000000);

        chk("no_stray_sram_write", 64'(stray), 64'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
